// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Drives en/clr for each inter-stage register and the PC enable. It resolves
// load-use stalls, taken-branch flushes, imem/dmem wait states and operand
// forwarding. It also keeps a stall-cycle counter and a dmem timeout watchdog.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int DMEM_TIMEOUT   = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      ex_branch_taken,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      mem_reg_write,
  input  logic                      wb_reg_write,
  input  logic                      imem_ready,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      if_id_clr,
  output logic                      id_ex_en,
  output logic                      id_ex_clr,
  output logic                      ex_mem_en,
  output logic                      ex_mem_clr,
  output logic                      mem_wb_en,
  output logic                      mem_wb_clr,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic [1:0]                state,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic                      err_timeout
);

  // Wide enough to hold DMEM_TIMEOUT-1 with headroom to saturate above it.
  localparam int WAIT_W = $clog2(DMEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_FETCH_WAIT = 2'b01,
    ST_MEM_WAIT   = 2'b10
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_WIDTH-1:0] stall_cnt_reg;
  logic [WAIT_W-1:0]    wait_cnt_reg;
  logic                 err_reg;

  logic dmem_busy;
  logic load_use;

  assign dmem_busy = dmem_req & ~dmem_ready;
  assign load_use  = ex_mem_read & (ex_rd != '0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Pipeline register controls by priority; a clr always comes with its en.
  always_comb begin
    pc_en      = 1'b1;
    if_id_en   = 1'b1;
    if_id_clr  = 1'b0;
    id_ex_en   = 1'b1;
    id_ex_clr  = 1'b0;
    ex_mem_en  = 1'b1;
    ex_mem_clr = 1'b0;
    mem_wb_en  = 1'b1;
    mem_wb_clr = 1'b0;
    if (rst) begin
      pc_en      = 1'b0;
      if_id_clr  = 1'b1;
      id_ex_clr  = 1'b1;
      ex_mem_clr = 1'b1;
      mem_wb_clr = 1'b1;
    end else if (dmem_busy) begin
      // Freeze everything up to MEM; WB gets a bubble so it never retires twice.
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      ex_mem_en  = 1'b0;
      mem_wb_clr = 1'b1;
    end else if (ex_branch_taken) begin
      // Branch held through a freeze lands here on the first non-busy cycle.
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
    end else if (load_use) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_clr = 1'b1;
    end else if (!imem_ready) begin
      pc_en     = 1'b0;
      if_id_clr = 1'b1;
    end
  end

  // Operand forwarding for both EX sources; MEM beats WB and x0 never forwards.
  logic [REG_ADDR_WIDTH-1:0] ex_src [2];
  logic [1:0]                fwd_sel [2];

  assign ex_src[0] = ex_rs1;
  assign ex_src[1] = ex_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      // Select the youngest in-flight producer of this operand.
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_src[gi])) begin
          fwd_sel[gi] = 2'b10;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_src[gi])) begin
          fwd_sel[gi] = 2'b01;
        end
      end
    end
  endgenerate

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

  // Next sequencing state, data-memory wait dominating fetch wait.
  always_comb begin
    state_next = ST_RUN;
    if (dmem_busy) begin
      state_next = ST_MEM_WAIT;
    end else if (!imem_ready && !ex_branch_taken && !load_use) begin
      state_next = ST_FETCH_WAIT;
    end
  end

  // State, stall counter, dmem wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      stall_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (!pc_en && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
      end
      if (dmem_busy) begin
        if (wait_cnt_reg != '1) begin
          wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
        end
        if (wait_cnt_reg == WAIT_W'(DMEM_TIMEOUT - 1)) begin
          err_reg <= 1'b1;
        end
      end else begin
        wait_cnt_reg <= '0;
      end
    end
  end

  assign state       = state_reg;
  assign stall_cnt   = stall_cnt_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector tables, hand-written
// multi-cycle sequences and randomized cycles against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;
  localparam int TO = 4;

  // Control vector order: {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr,
  //                        ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr}
  localparam logic [8:0] C_RST = 9'b0_11_11_11_11;
  localparam logic [8:0] C_FRZ = 9'b0_00_00_00_11;
  localparam logic [8:0] C_BR  = 9'b1_11_11_10_10;
  localparam logic [8:0] C_LU  = 9'b0_00_11_10_10;
  localparam logic [8:0] C_FW  = 9'b0_11_10_10_10;
  localparam logic [8:0] C_RUN = 9'b1_10_10_10_10;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic mem_reg_write, wb_reg_write, imem_ready, dmem_req, dmem_ready;
  logic pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr;
  logic ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr;
  logic [1:0] fwd_a, fwd_b, state;
  logic [CW-1:0] stall_cnt;
  logic err_timeout;
  logic [8:0] dut_ctrl;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int            m_state;
  logic [CW-1:0] m_stall;
  int            m_wait;
  logic          m_err;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW), .DMEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_clr(if_id_clr),
    .id_ex_en(id_ex_en), .id_ex_clr(id_ex_clr), .ex_mem_en(ex_mem_en),
    .ex_mem_clr(ex_mem_clr), .mem_wb_en(mem_wb_en), .mem_wb_clr(mem_wb_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .stall_cnt(stall_cnt),
    .err_timeout(err_timeout)
  );

  assign dut_ctrl = {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr,
                     ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_load_use();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [8:0] exp_ctrl();
    if (rst) return C_RST;
    if (dmem_req && !dmem_ready) return C_FRZ;
    if (ex_branch_taken) return C_BR;
    if (is_load_use()) return C_LU;
    if (!imem_ready) return C_FW;
    return C_RUN;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] src);
    if (src == 0) return 2'b00;
    if (mem_reg_write && mem_rd == src) return 2'b10;
    if (wb_reg_write && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    rst = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = '0; wb_rd = '0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Mid-cycle: compare every DUT output with the model.
  task automatic sample();
    @(negedge clk);
    chk("ctrl", 32'(dut_ctrl), 32'(exp_ctrl()));
    chk("fwd_a", 32'(fwd_a), 32'(exp_fwd(ex_rs1)));
    chk("fwd_b", 32'(fwd_b), 32'(exp_fwd(ex_rs2)));
    chk("state", 32'(state), 32'(m_state));
    chk("stall_cnt", stall_cnt, m_stall);
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
  endtask

  // Clock edge: advance the model with this cycle's inputs.
  task automatic advance();
    logic busy;
    logic [8:0] c;
    @(posedge clk);
    busy = dmem_req && !dmem_ready;
    c = exp_ctrl();
    if (rst) begin
      m_state = 0; m_stall = '0; m_wait = 0; m_err = 1'b0;
    end else begin
      if (!c[8] && m_stall != '1) m_stall = m_stall + 1;
      if (busy) begin
        if (m_wait == TO - 1) m_err = 1'b1;
        m_wait++;
      end else begin
        m_wait = 0;
      end
      if (busy) m_state = 2;
      else if (!imem_ready && !ex_branch_taken && !is_load_use()) m_state = 1;
      else m_state = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1;
    sample(); advance();
    rst = 1'b0;
  endtask

  typedef struct {
    logic rst, dreq, drdy, br, mrd;
    logic [AW-1:0] exrd, rs1;
    logic u1, imem;
    logic [8:0] exp;
  } ctrl_vec_t;

  typedef struct {
    logic mrw;
    logic [AW-1:0] mrd;
    logic wrw;
    logic [AW-1:0] wrd, rs1, rs2;
    logic [1:0] ea, eb;
  } fwd_vec_t;

  ctrl_vec_t cv [12];
  fwd_vec_t  fv [6];

  initial begin
    cv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, C_RUN};
    cv[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, C_LU};
    cv[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, C_RUN};
    cv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b0, 1'b1, C_RUN};
    cv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, C_BR};
    cv[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 5'd6, 1'b1, 1'b1, C_BR};
    cv[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, C_FRZ};
    cv[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, C_BR};
    cv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, C_FW};
    cv[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 1'b0, C_LU};
    cv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, C_BR};
    cv[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 1'b0, C_RST};

    fv[0] = '{1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 5'd7, 2'b10, 2'b10};
    fv[1] = '{1'b0, 5'd7, 1'b1, 5'd7, 5'd7, 5'd3, 2'b01, 2'b00};
    fv[2] = '{1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
    fv[3] = '{1'b1, 5'd3, 1'b1, 5'd4, 5'd4, 5'd3, 2'b01, 2'b10};
    fv[4] = '{1'b0, 5'd3, 1'b0, 5'd3, 5'd3, 5'd3, 2'b00, 2'b00};
    fv[5] = '{1'b1, 5'd12, 1'b0, 5'd12, 5'd1, 5'd12, 2'b00, 2'b10};

    m_state = 0; m_stall = '0; m_wait = 0; m_err = 1'b0;
    idle(); rst = 1'b1;
    #1;
    do_reset();

    // Control vector table
    for (int i = 0; i < 12; i++) begin
      idle();
      rst = cv[i].rst; dmem_req = cv[i].dreq; dmem_ready = cv[i].drdy;
      ex_branch_taken = cv[i].br; ex_mem_read = cv[i].mrd; ex_rd = cv[i].exrd;
      id_rs1 = cv[i].rs1; id_uses_rs1 = cv[i].u1; imem_ready = cv[i].imem;
      sample();
      chk("ctrl_vec", 32'(dut_ctrl), 32'(cv[i].exp));
      $display("[TB] ctrl vec %0d ctrl=%b exp=%b", i, dut_ctrl, cv[i].exp);
      advance();
    end

    // Forwarding vector table
    for (int i = 0; i < 6; i++) begin
      idle();
      mem_reg_write = fv[i].mrw; mem_rd = fv[i].mrd; wb_reg_write = fv[i].wrw;
      wb_rd = fv[i].wrd; ex_rs1 = fv[i].rs1; ex_rs2 = fv[i].rs2;
      sample();
      chk("fwd_vec_a", 32'(fwd_a), 32'(fv[i].ea));
      chk("fwd_vec_b", 32'(fwd_b), 32'(fv[i].eb));
      $display("[TB] fwd vec %0d a=%b b=%b", i, fwd_a, fwd_b);
      advance();
    end

    // Load-use stall counts one cycle
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    sample();
    chk("lu_pc_en", 32'(pc_en), 0); chk("lu_if_id_en", 32'(if_id_en), 0);
    chk("lu_id_ex_clr", 32'(id_ex_clr), 1); chk("lu_cnt0", stall_cnt, 0);
    advance(); idle();
    sample();
    chk("lu_cnt1", stall_cnt, 1); chk("lu_release", 32'(pc_en), 1);
    $display("[TB] load-use stall_cnt=%0d", stall_cnt);
    advance();

    // Branch flush stays in RUN
    ex_branch_taken = 1'b1;
    sample();
    chk("br_flush", 32'(dut_ctrl), 32'(C_BR));
    advance(); idle();
    sample();
    chk("br_state", 32'(state), 0);
    $display("[TB] branch flush state=%0d", state);
    advance();

    // Dmem freeze with a branch pending for 3 cycles
    do_reset();
    dmem_req = 1'b1; ex_branch_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("frz_ctrl", 32'(dut_ctrl), 32'(C_FRZ));
      if (k > 0) chk("frz_state", 32'(state), 2);
      $display("[TB] dmem freeze cycle %0d ctrl=%b", k, dut_ctrl);
      advance();
    end
    dmem_ready = 1'b1;
    sample();
    chk("frz_release_flush", 32'(dut_ctrl), 32'(C_BR));
    chk("frz_stall_cnt", stall_cnt, 3);
    advance(); idle();

    // Watchdog timeout after TO busy cycles, sticky until reset
    do_reset();
    dmem_req = 1'b1;
    for (int k = 0; k < TO; k++) begin
      sample();
      chk("to_not_yet", 32'(err_timeout), 0);
      advance();
    end
    dmem_ready = 1'b1;
    sample();
    chk("to_set", 32'(err_timeout), 1);
    advance(); idle();
    sample();
    chk("to_sticky", 32'(err_timeout), 1);
    advance();
    rst = 1'b1;
    sample(); advance(); rst = 1'b0;
    sample();
    chk("to_cleared", 32'(err_timeout), 0);
    $display("[TB] timeout sequence err=%0d", err_timeout);
    advance();

    // Fetch wait, then reset mid-wait
    imem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("fw_ctrl", 32'(dut_ctrl), 32'(C_FW));
      if (k > 0) chk("fw_state", 32'(state), 1);
      advance();
    end
    rst = 1'b1;
    sample();
    chk("fw_rst_ctrl", 32'(dut_ctrl), 32'(C_RST));
    advance();
    idle();
    sample();
    chk("fw_rst_state", 32'(state), 0); chk("fw_rst_cnt", stall_cnt, 0);
    $display("[TB] fetch wait reset state=%0d cnt=%0d", state, stall_cnt);
    advance();

    // Randomized cycles against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      ex_rs1 = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
      ex_rd = AW'($urandom_range(0, 3)); ex_mem_read = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_rd = AW'($urandom_range(0, 3)); wb_rd = AW'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      imem_ready = ($urandom_range(0, 3) != 0);
      dmem_req = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 2) == 0);
      sample();
      $display("[TB] rand %0d ctrl=%b fwd=%b/%b st=%0d cnt=%0d err=%0d",
               n, dut_ctrl, fwd_a, fwd_b, state, stall_cnt, err_timeout);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32 pipeline. It drives the en/clr pair of every inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It resolves load-use stalls, taken-branch flushes, instruction- and data-memory wait states and operand forwarding. It also keeps a stall-cycle counter and a data-memory timeout watchdog.

Parameters:
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 32, stall counter width (saturating)
DMEM_TIMEOUT, 256, consecutive dmem wait cycles before err_timeout sets (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_rs1, id_rs2  in  REG_ADDR_WIDTH  source regs of instruction in ID
id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2
ex_rs1, ex_rs2  in  REG_ADDR_WIDTH  source regs of instruction in EX
ex_rd  in  REG_ADDR_WIDTH  EX destination
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved taken branch/jump
mem_rd, wb_rd  in  REG_ADDR_WIDTH  MEM/WB destinations
mem_reg_write, wb_reg_write  in  1  MEM/WB write rd
imem_ready  in  1  fetch data valid this cycle
dmem_req  in  1  MEM stage has an access outstanding
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register enable
if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr  out  1 each  pipeline register controls
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
state  out  2  00 RUN, 01 FETCH_WAIT, 10 MEM_WAIT
stall_cnt  out  CNT_WIDTH  cycles with pc_en=0 since reset
err_timeout  out  1  sticky dmem timeout flag

Behaviour:
- Control outputs are combinational from inputs; state, stall_cnt, wait counter and err_timeout are registered.
- Whenever any *_clr=1, the matching *_en is also driven 1.
- Definitions: dmem_busy = dmem_req & ~dmem_ready. load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Cycle priority, highest first:
  1. rst=1: all four clr=1, pc_en=0.
  2. dmem_busy: pc_en, if_id_en, id_ex_en and ex_mem_en = 0 (freeze). mem_wb_clr=1 (bubble into WB).
  3. ex_branch_taken: pc_en=1, if_id_clr=1, id_ex_clr=1, ex_mem_en=1, mem_wb_en=1.
  4. load_use: pc_en=0, if_id_en=0, id_ex_clr=1, ex_mem_en=1, mem_wb_en=1.
  5. ~imem_ready: pc_en=0, if_id_clr=1, id_ex_en=1, ex_mem_en=1, mem_wb_en=1.
  6. Otherwise all en=1, all clr=0, pc_en=1.
- A branch held in EX during a dmem freeze flushes on the first cycle dmem_busy drops.
- Forwarding for fwd_a (fwd_b identical with ex_rs2):
  - 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1.
  - else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
  - else 00.
  - MEM beats WB. Never forward for x0. Forwarding is evaluated every cycle, independent of stalls.
- State register, next value by priority:
  - MEM_WAIT if dmem_busy.
  - else FETCH_WAIT if ~imem_ready & ~ex_branch_taken & ~load_use.
  - else RUN.
  - Reset value RUN.
- stall_cnt: reset 0. Increments by 1 on each non-reset cycle with pc_en=0. Saturates at all-ones.
- Wait counter: reset 0. Cleared on any cycle with dmem_busy=0. Increments (saturating) while dmem_busy=1.
- err_timeout:
  - Sets at the clock edge ending a cycle in which dmem_busy=1 and the wait counter equals DMEM_TIMEOUT-1.
  - Cleared only by rst. Does not alter stall behaviour.
- Reset asserted mid-stall: next cycle state=RUN, counters=0, err_timeout=0. While rst is held, outputs follow priority 1.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, imem_ready=1 -> pc_en=0, if_id_en=0, id_ex_clr=1 for one cycle. stall_cnt increments 0->1. Repeat with ex_rd=0 -> no stall.
- Branch flush: ex_branch_taken=1 -> if_id_clr=1, id_ex_clr=1, pc_en=1. State remains RUN.
- Dmem wait with branch pending: dmem_req=1, dmem_ready=0 for 3 cycles, ex_branch_taken=1 throughout -> 3 cycles of pc_en=0, mem_wb_clr=1, state=MEM_WAIT. The cycle dmem_ready=1 -> flush outputs. stall_cnt=3.
- Timeout: DMEM_TIMEOUT=4, dmem_busy held 4 cycles -> err_timeout=1 from the 5th cycle. Remains 1 after dmem_ready. Cleared by a 1-cycle rst.
- Forwarding: mem_rd=wb_rd=ex_rs1=7, both reg_write=1 -> fwd_a=10. mem_reg_write=0 -> 01. All rd=0 -> 00.
- Fetch wait: imem_ready=0 for 2 cycles -> pc_en=0, if_id_clr=1, state=FETCH_WAIT. Asserting rst mid-wait -> all clr=1, then state=RUN, stall_cnt=0.
